// File: rtl/uart_host_s_if.sv
// IO-bus bundle between uart_host_s (master) and a uart_s register window (slave).
// bus_in is the peripheral read data, valid combinationally while rd is high.
interface uart_host_s_if #(
    parameter int ADDR_W = 16
) ();
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              rd;
    logic [7:0]        bus_out;
    logic [7:0]        bus_in;

    modport master (
        output addr,
        output wr,
        output rd,
        output bus_out,
        input  bus_in
    );

    modport slave (
        input  addr,
        input  wr,
        input  rd,
        input  bus_out,
        output bus_in
    );
endinterface

// File: rtl/uart_host_s.sv
// Bus initiator that configures a uart_s USART once, then streams a TX FIFO into its DATA register.
// Optional receive path (status-polled reads of DATA) is enabled with `define UART_HOST_RX_EN.
module uart_host_s #(
    parameter int          USART_ADDRESS     = 0,
    parameter int          BUS_ADDR_DATA_LEN = 16,
    parameter int          FIFO_AW           = 4,
    parameter logic [11:0] BAUD_VALUE        = 12'd103,
    parameter logic [7:0]  CTRLC_VALUE       = 8'h03
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_host_s_if.master        bus,
    input  logic [7:0]           tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    output logic                 rx_err,
    output logic                 init_done
);

    localparam int AW    = BUS_ADDR_DATA_LEN;
    localparam int CW    = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;

    // uart_s register offsets and bit positions
    localparam logic [3:0] OFF_DATA   = 4'd0;
    localparam logic [3:0] OFF_STATUS = 4'd1;
    localparam logic [3:0] OFF_CTRLB  = 4'd4;
    localparam logic [3:0] OFF_CTRLC  = 4'd5;
    localparam logic [3:0] OFF_BAUDA  = 4'd6;
    localparam logic [3:0] OFF_BAUDB  = 4'd7;
    localparam int RXCIF_BIT  = 7;
    localparam int DREIF_BIT  = 5;
    localparam int FERR_BIT   = 4;
    localparam int BUFOVF_BIT = 3;
    localparam int PERR_BIT   = 2;
    localparam logic [7:0] TXEN_MASK = 8'h08;
    localparam logic [7:0] RXEN_MASK = 8'h10;

`ifdef UART_HOST_RX_EN
    localparam logic RX_EN = 1'b1;
`else
    localparam logic RX_EN = 1'b0;
`endif

    localparam logic [7:0]    CTRLB_VALUE = RX_EN ? (TXEN_MASK | RXEN_MASK) : TXEN_MASK;
    localparam logic [CW-1:0] CNT_FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ZERO = FIFO_AW'(0);
    localparam logic [AW-1:0]      ADDR_ZERO = AW'(0);

    // st_q holds only the STATUS flags the sequencer acts on: {RXCIF, DREIF, FERR, BUFOVF, PERR}
    localparam int ST_RXC = 4;
    localparam int ST_DRE = 3;
    localparam int ST_FE  = 2;
    localparam int ST_BOV = 1;
    localparam int ST_PE  = 0;

    typedef enum logic [3:0] {
        S_INIT0  = 4'd0,
        S_INIT1  = 4'd1,
        S_INIT2  = 4'd2,
        S_INIT3  = 4'd3,
        S_IDLE   = 4'd4,
        S_POLL   = 4'd5,
        S_DECIDE = 4'd6,
        S_WRDATA = 4'd7,
        S_RDDATA = 4'd8
    } state_t;

    function automatic logic [AW-1:0] reg_addr(input logic [3:0] off);
        return AW'(USART_ADDRESS) + AW'(off);
    endfunction

    state_t              state_q;
    logic [AW-1:0]       addr_q;
    logic                wr_q;
    logic                rd_q;
    logic [7:0]          bus_out_q;
    logic [4:0]          st_q;
    logic [7:0]          rx_data_q;
    logic                rx_valid_q;
    logic                rx_err_q;
    logic                init_done_q;

    logic [FIFO_AW-1:0]  wptr_q;
    logic [FIFO_AW-1:0]  rptr_q;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic [7:0]          mem_q [DEPTH];

    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                push_s;
    logic                pop_s;

    assign fifo_full_s  = (count_q == CNT_FULL);
    assign fifo_empty_s = (count_q == CNT_ZERO);
    assign tx_ready     = init_done_q & ~fifo_full_s;
    assign push_s       = tx_valid & tx_ready;
    // The head byte is already on bus_out during WRDATA, so the pop lands on the edge that ends it.
    assign pop_s        = (state_q == S_WRDATA);

    // Occupancy next-state
    always_comb begin
        count_d = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= PTR_ZERO;
            rptr_q  <= PTR_ZERO;
            count_q <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= tx_data;
        end
    end

    // Bus sequencer: outputs are registered on the edge entering the state that shows them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_INIT0;
            addr_q      <= ADDR_ZERO;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            bus_out_q   <= 8'h00;
            st_q        <= 5'b00000;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_err_q    <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            addr_q     <= ADDR_ZERO;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            bus_out_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            case (state_q)
                S_INIT0: begin
                    wr_q      <= 1'b1;
                    addr_q    <= reg_addr(OFF_BAUDB);
                    bus_out_q <= {4'h0, BAUD_VALUE[11:8]};
                    state_q   <= S_INIT1;
                end
                S_INIT1: begin
                    wr_q      <= 1'b1;
                    addr_q    <= reg_addr(OFF_BAUDA);
                    bus_out_q <= BAUD_VALUE[7:0];
                    state_q   <= S_INIT2;
                end
                S_INIT2: begin
                    wr_q      <= 1'b1;
                    addr_q    <= reg_addr(OFF_CTRLC);
                    bus_out_q <= CTRLC_VALUE;
                    state_q   <= S_INIT3;
                end
                S_INIT3: begin
                    wr_q      <= 1'b1;
                    addr_q    <= reg_addr(OFF_CTRLB);
                    bus_out_q <= CTRLB_VALUE;
                    state_q   <= S_IDLE;
                end
                S_IDLE: begin
                    init_done_q <= 1'b1;
                    if (RX_EN || !fifo_empty_s) begin
                        rd_q    <= 1'b1;
                        addr_q  <= reg_addr(OFF_STATUS);
                        state_q <= S_POLL;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_POLL: begin
                    st_q    <= {bus.bus_in[RXCIF_BIT], bus.bus_in[DREIF_BIT], bus.bus_in[FERR_BIT],
                                bus.bus_in[BUFOVF_BIT], bus.bus_in[PERR_BIT]};
                    state_q <= S_DECIDE;
                end
                S_DECIDE: begin
                    // Receive is served first so a pending character cannot be overrun.
                    if (RX_EN && st_q[ST_RXC]) begin
                        rd_q    <= 1'b1;
                        addr_q  <= reg_addr(OFF_DATA);
                        state_q <= S_RDDATA;
                    end else if (st_q[ST_DRE] && !fifo_empty_s) begin
                        wr_q      <= 1'b1;
                        addr_q    <= reg_addr(OFF_DATA);
                        bus_out_q <= mem_q[rptr_q];
                        state_q   <= S_WRDATA;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WRDATA: begin
                    state_q <= S_IDLE;
                end
                S_RDDATA: begin
                    rx_data_q  <= bus.bus_in;
                    rx_err_q   <= st_q[ST_FE] | st_q[ST_PE] | st_q[ST_BOV];
                    rx_valid_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_INIT0;
                end
            endcase
        end
    end

    assign bus.addr    = addr_q;
    assign bus.wr      = wr_q;
    assign bus.rd      = rd_q;
    assign bus.bus_out = bus_out_q;
    assign init_done   = init_done_q;
    assign rx_data     = RX_EN ? rx_data_q : 8'h00;
    assign rx_valid    = RX_EN ? rx_valid_q : 1'b0;
    assign rx_err      = RX_EN ? rx_err_q : 1'b0;

endmodule

// File: tb/tb_uart_host_s.sv
// Directed testbench for uart_host_s with a tiny uart_s register model on the IO bus.
module tb_uart_host_s;
    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       init_done;
    logic [7:0] status_r;
    logic [7:0] rxbyte_r;
    logic       both_seen = 1'b0;
    int         n_checks  = 0;
    int         n_errors  = 0;
    logic [15:0] wlog_addr [$];
    logic [7:0]  wlog_data [$];
    logic [7:0]  evlog [$];

`ifdef UART_HOST_RX_EN
    localparam logic [7:0] EXP_CTRLB = 8'h18;
`else
    localparam logic [7:0] EXP_CTRLB = 8'h08;
`endif

    uart_host_s_if #(.ADDR_W(16)) bus_if ();

    uart_host_s #(
        .USART_ADDRESS    (0),
        .BUS_ADDR_DATA_LEN(16),
        .FIFO_AW          (4),
        .BAUD_VALUE       (12'd103),
        .CTRLC_VALUE      (8'h03)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .init_done(init_done)
    );

    assign bus_if.bus_in = (bus_if.rd && bus_if.addr == 16'd1) ? status_r :
                           (bus_if.rd && bus_if.addr == 16'd0) ? rxbyte_r : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral-side log of bus transactions, sampled mid-cycle
    always @(negedge clk) begin
        if (bus_if.wr) begin
            wlog_addr.push_back(bus_if.addr);
            wlog_data.push_back(bus_if.bus_out);
        end
        if (bus_if.rd && bus_if.addr == 16'd0) evlog.push_back(8'd82);
        if (bus_if.wr && bus_if.addr == 16'd0) evlog.push_back(8'd87);
        if (bus_if.wr && bus_if.rd) both_seen <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    function automatic logic [15:0] init_addr(input int i);
        case (i)
            0:       return 16'd7;
            1:       return 16'd6;
            2:       return 16'd5;
            default: return 16'd4;
        endcase
    endfunction

    function automatic logic [7:0] init_data(input int i);
        case (i)
            0:       return 8'h00;
            1:       return 8'h67;
            2:       return 8'h03;
            default: return EXP_CTRLB;
        endcase
    endfunction

    // Called at the negedge where rst is released; checks the four config writes.
    task automatic check_init();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("init%0d_wr", i), bus_if.wr, 1);
            check_eq($sformatf("init%0d_addr", i), bus_if.addr, init_addr(i));
            check_eq($sformatf("init%0d_data", i), bus_if.bus_out, init_data(i));
            check_eq($sformatf("init%0d_done_low", i), init_done, 0);
        end
        @(negedge clk);
        check_eq("init_done", init_done, 1);
        check_eq("tx_ready_after_init", tx_ready, 1);
        check_eq("wr_after_init", bus_if.wr, 0);
    endtask

    task automatic wait_writes(input int mark, input int n);
        for (int k = 0; k < 400 && (wlog_data.size() - mark) < n; k++) @(negedge clk);
        repeat (12) @(negedge clk);
        check_eq("write_count", wlog_data.size() - mark, n);
    endtask

    task automatic wait_rx(output logic got);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (rx_valid) got = 1'b1;
        end
    endtask

    initial begin
        int   mark;
        int   emark;
        logic found;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        status_r = 8'h00;
        rxbyte_r = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_init_done", init_done, 0);
        check_eq("rst_tx_ready", tx_ready, 0);
        check_eq("rst_wr", bus_if.wr, 0);
        check_eq("rst_addr", bus_if.addr, 0);
        check_eq("rst_rx_valid", rx_valid, 0);
        rst = 1'b0;
        check_init();

        // Single byte with DREIF set
        status_r = 8'h20;
`ifndef UART_HOST_RX_EN
        push(8'h55);
        check_eq("t1_idle_rd", bus_if.rd, 0);
        @(negedge clk);
        check_eq("t1_poll_rd", bus_if.rd, 1);
        check_eq("t1_poll_addr", bus_if.addr, 16'd1);
        @(negedge clk);
        check_eq("t1_decide_rd", bus_if.rd, 0);
        check_eq("t1_decide_wr", bus_if.wr, 0);
        @(negedge clk);
        check_eq("t1_wr", bus_if.wr, 1);
        check_eq("t1_wr_addr", bus_if.addr, 16'd0);
        check_eq("t1_wr_data", bus_if.bus_out, 8'h55);
        @(negedge clk);
        check_eq("t1_wr_end", bus_if.wr, 0);
        check_eq("t1_bus_out_end", bus_if.bus_out, 0);
`else
        mark = wlog_data.size();
        push(8'h55);
        wait_writes(mark, 1);
        if (wlog_data.size() > mark) check_eq("t1_wr_data", wlog_data[mark], 8'h55);
`endif

        // Fill to full with DREIF clear, then drain
        status_r = 8'h00;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        check_eq("full_tx_ready", tx_ready, 0);
        push(8'hEE);
        check_eq("full_tx_ready_hold", tx_ready, 0);
        mark = wlog_data.size();
        status_r = 8'h20;
        wait_writes(mark, 16);
        for (int i = 0; i < 16 && mark + i < wlog_data.size(); i++) begin
            check_eq($sformatf("drain%0d_data", i), wlog_data[mark + i], 8'h10 + 8'(i));
            check_eq($sformatf("drain%0d_addr", i), wlog_addr[mark + i], 16'd0);
        end
        check_eq("drain_tx_ready", tx_ready, 1);

        // Pointer wrap
        mark = wlog_data.size();
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        wait_writes(mark, 4);
        for (int i = 0; i < 4 && mark + i < wlog_data.size(); i++)
            check_eq($sformatf("wrap%0d_data", i), wlog_data[mark + i], 8'hA0 + 8'(i));

`ifdef UART_HOST_RX_EN
        // RX and TX both pending: read goes first
        status_r = 8'h00;
        push(8'h3C);
        repeat (6) @(negedge clk);
        mark  = wlog_data.size();
        emark = evlog.size();
        rxbyte_r = 8'hA3;
        status_r = 8'hA0;
        wait_rx(found);
        status_r = 8'h20;
        check_eq("rxa_seen", found, 1);
        check_eq("rxa_data", rx_data, 8'hA3);
        check_eq("rxa_err", rx_err, 0);
        @(negedge clk);
        check_eq("rxa_pulse", rx_valid, 0);
        wait_writes(mark, 1);
        if (wlog_data.size() > mark) check_eq("rxa_tx_data", wlog_data[mark], 8'h3C);
        if (evlog.size() > emark + 1) begin
            check_eq("rxa_order0", evlog[emark], 8'd82);
            check_eq("rxa_order1", evlog[emark + 1], 8'd87);
        end else begin
            check_eq("rxa_events", evlog.size() - emark, 2);
        end

        // Framing error flagged on its byte only
        rxbyte_r = 8'h5A;
        status_r = 8'h90;
        wait_rx(found);
        status_r = 8'h80;
        rxbyte_r = 8'h6B;
        check_eq("rxb_seen", found, 1);
        check_eq("rxb_data", rx_data, 8'h5A);
        check_eq("rxb_err", rx_err, 1);
        wait_rx(found);
        status_r = 8'h00;
        check_eq("rxc_seen", found, 1);
        check_eq("rxc_data", rx_data, 8'h6B);
        check_eq("rxc_err", rx_err, 0);
`endif

        // Reset during WRDATA
        status_r = 8'h20;
        push(8'h77);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus_if.wr) found = 1'b1;
        end
        check_eq("rst_wr_reached", found, 1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_wr", bus_if.wr, 0);
        check_eq("mid_rst_rd", bus_if.rd, 0);
        check_eq("mid_rst_addr", bus_if.addr, 0);
        check_eq("mid_rst_bus_out", bus_if.bus_out, 0);
        check_eq("mid_rst_init_done", init_done, 0);
        check_eq("mid_rst_tx_ready", tx_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        check_init();
        mark = wlog_data.size();
        repeat (12) @(negedge clk);
        check_eq("post_rst_fifo_empty", wlog_data.size() - mark, 0);
        check_eq("post_rst_tx_ready", tx_ready, 1);
        check_eq("wr_rd_exclusive", both_seen, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
